// File: rtl/rename_stage.sv
// rtl/rename_stage.sv - register rename: speculative/committed RAT, circular free list, registered bundle
module rename_stage #(
  parameter int NUM_PREGS = 64,
  parameter int PTAG_W    = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid_r,
  input  logic [4:0]        rs1_r,
  input  logic [4:0]        rs2_r,
  input  logic [4:0]        rd_r,
  input  logic              reg_write_r,
  output logic              hold_dr,
  input  logic              dispatch_ready,
  output logic              ren_valid,
  output logic [PTAG_W-1:0] prs1,
  output logic [PTAG_W-1:0] prs2,
  output logic [PTAG_W-1:0] prd,
  output logic [PTAG_W-1:0] old_prd,
  output logic              prd_alloc,
  input  logic              commit_valid,
  input  logic              commit_reg_write,
  input  logic [4:0]        commit_rd,
  input  logic [PTAG_W-1:0] commit_prd,
  input  logic [PTAG_W-1:0] commit_old_prd,
  input  logic              flush,
  output logic [PTAG_W:0]   free_count
);

  localparam logic [PTAG_W:0] PTR_ONE  = (PTAG_W+1)'(1);
  localparam logic [PTAG_W:0] INIT_CNT = (PTAG_W+1)'(NUM_PREGS - 32);

  logic [PTAG_W-1:0] spec_rat  [32];
  logic [PTAG_W-1:0] comm_rat  [32];
  logic [PTAG_W-1:0] free_list [NUM_PREGS];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTAG_W:0] head, tail, commit_head;

  logic alloc_need, stall, accept, commit_fire;

  assign free_count  = tail - head;
  assign alloc_need  = reg_write_r && (rd_r != 5'd0);
  assign stall       = (ren_valid && !dispatch_ready) || (alloc_need && (free_count == '0));
  assign hold_dr     = stall;
  assign accept      = instr_valid_r && !stall && !flush;
  assign commit_fire = commit_valid && commit_reg_write && (commit_rd != 5'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        spec_rat[i] <= PTAG_W'(i);
        comm_rat[i] <= PTAG_W'(i);
      end
      for (int i = 0; i < NUM_PREGS; i++)
        free_list[i] <= (i < NUM_PREGS - 32) ? PTAG_W'(i + 32) : '0;
      head        <= '0;
      commit_head <= '0;
      tail        <= INIT_CNT;
      ren_valid   <= 1'b0;
      prs1        <= '0;
      prs2        <= '0;
      prd         <= '0;
      old_prd     <= '0;
      prd_alloc   <= 1'b0;
    end else begin
      if (commit_fire) begin
        comm_rat[commit_rd]            <= commit_prd;
        free_list[tail[PTAG_W-1:0]]    <= commit_old_prd;
        tail                           <= tail + PTR_ONE;
        commit_head                    <= commit_head + PTR_ONE;
      end

      // Flush rebuilds the speculative map from the committed one, folding in this cycle's commit.
      if (flush) begin
        for (int i = 0; i < 32; i++)
          spec_rat[i] <= (commit_fire && commit_rd == 5'(i)) ? commit_prd : comm_rat[i];
        head      <= commit_head + (PTAG_W+1)'(commit_fire);
        ren_valid <= 1'b0;
      end else if (accept) begin
        ren_valid <= 1'b1;
        prs1      <= spec_rat[rs1_r];
        prs2      <= spec_rat[rs2_r];
        if (alloc_need) begin
          prd             <= free_list[head[PTAG_W-1:0]];
          old_prd         <= spec_rat[rd_r];
          prd_alloc       <= 1'b1;
          spec_rat[rd_r]  <= free_list[head[PTAG_W-1:0]];
          head            <= head + PTR_ONE;
        end else begin
          prd       <= '0;
          old_prd   <= '0;
          prd_alloc <= 1'b0;
        end
      end else if (ren_valid && dispatch_ready) begin
        ren_valid <= 1'b0;
      end
    end
  end

  // Returning p0 would put the hardwired x0 register into circulation.
  always_ff @(posedge clk) begin
    if (!reset && commit_fire)
      assert (commit_old_prd != '0);
  end

endmodule
